// File: rtl/circuit_pair.sv
// circuit_pair: two 4-bit register pairs sharing inputs; circuit forwards the new
// first-stage value to its second stage, circuit2 uses the old one (true pipeline).
module circuit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  input  logic             Clock,
  input  logic             Reset,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] c
);
  logic [WIDTH-1:0] a_q, a_d, c_q, c_d;
  // c is loaded from the same sum a is being loaded with on this edge
  always_comb begin
    a_d = b + d;
    c_d = a_d + WIDTH'(1);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      c_q <= c_d;
    end
  end
  assign a = a_q;
  assign c = c_q;
endmodule

module circuit2 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  input  logic             Clock,
  input  logic             Reset,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] c
);
  logic [WIDTH-1:0] a_q, a_d, c_q, c_d;
  // c sees a's value from before this edge, adding one stage of latency
  always_comb begin
    a_d = b + d;
    c_d = a_q + WIDTH'(1);
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      c_q <= c_d;
    end
  end
  assign a = a_q;
  assign c = c_q;
endmodule

module circuit_pair #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] c2
);
  circuit #(.WIDTH(WIDTH)) u_circuit (
    .b(b), .d(d), .Clock(Clock), .Reset(Reset), .a(a1), .c(c1)
  );
  circuit2 #(.WIDTH(WIDTH)) u_circuit2 (
    .b(b), .d(d), .Clock(Clock), .Reset(Reset), .a(a2), .c(c2)
  );
endmodule

// File: tb/tb_circuit_pair.sv
// tb_circuit_pair: random stimulus checked each negedge against a sum-history
// model, plus directed literal checks from hand-worked sequences.
module tb_circuit_pair;
  logic       Clock, Reset;
  logic [3:0] b, d;
  logic [3:0] a1, c1, a2, c2;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] hist[$];

  circuit_pair #(.WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .b(b), .d(d),
    .a1(a1), .c1(c1), .a2(a2), .c2(c2)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  // Model: the sums accepted since the last reset; only the newest two matter.
  always @(posedge Clock) begin
    if (Reset) hist.delete();
    else begin
      hist.push_back(4'(b + d));
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end
  always @(posedge Reset) hist.delete();

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    logic [3:0] ea, ec1, ec2;
    int n;
    n = hist.size();
    ea  = n == 0 ? 4'd0 : hist[n-1];
    ec1 = n == 0 ? 4'd0 : 4'(hist[n-1] + 4'd1);
    ec2 = n == 0 ? 4'd0 : n == 1 ? 4'd1 : 4'(hist[n-2] + 4'd1);
    check("model_a1", a1, ea);
    check("model_c1", c1, ec1);
    check("model_a2", a2, ea);
    check("model_c2", c2, ec2);
  end

  task automatic check4(input string tag, input logic [3:0] ea1, input logic [3:0] ec1,
                        input logic [3:0] ea2, input logic [3:0] ec2);
    check({tag, "_a1"}, a1, ea1);
    check({tag, "_c1"}, c1, ec1);
    check({tag, "_a2"}, a2, ea2);
    check({tag, "_c2"}, c2, ec2);
  endtask

  task automatic step(input logic [3:0] nb, input logic [3:0] nd);
    @(posedge Clock);
    #1;
    b = nb;
    d = nd;
  endtask

  initial begin
    Reset = 1;
    b = 2;
    d = 2;
    @(posedge Clock);
    #1 check4("rst_e1", 0, 0, 0, 0);
    @(posedge Clock);
    #1 check4("rst_e2", 0, 0, 0, 0);
    @(negedge Clock);
    #2 Reset = 0;
    @(posedge Clock);
    #1 check4("first", 4, 5, 4, 1);
    @(posedge Clock);
    #1 check4("second", 4, 5, 4, 5);
    b = 3; d = 1;
    @(posedge Clock);
    #1 check4("same_sum", 4, 5, 4, 5);
    b = 9; d = 7;
    @(posedge Clock);
    #1 check4("wrap0", 0, 1, 0, 5);
    @(posedge Clock);
    #1 check4("wrap0_b", 0, 1, 0, 1);
    b = 8; d = 7;
    @(posedge Clock);
    #1 check4("sum15", 15, 0, 15, 1);
    @(posedge Clock);
    #1 check4("sum15_b", 15, 0, 15, 0);
    b = 5; d = 5;
    @(posedge Clock);
    #1 check4("ten", 10, 11, 10, 0);
    @(posedge Clock);
    #1 check4("ten_b", 10, 11, 10, 11);
    #2 Reset = 1;
    #1 check4("async_rst", 0, 0, 0, 0);
    #2 Reset = 0;
    @(posedge Clock);
    #1 check4("restart", 10, 11, 10, 1);
    for (int i = 0; i < 500; i++) begin
      step(4'($urandom), 4'($urandom));
      case ($urandom_range(0, 15))
        0: begin #1 Reset = 1; #1 Reset = 0; end
        1: begin
          Reset = 1;
          @(posedge Clock);
          #2 Reset = 0;
        end
        default: ;
      endcase
    end
    @(posedge Clock);
    @(negedge Clock);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
